priority_encoder_pending: RTL

- Parametrised, registered successor to the team's 4-input combinational priority encoder.
- Captures N request lines into a sticky pending register and selects the highest-index pending request (MSB = highest priority, as in the 4-bit encoder).
- Presents the selection as a registered index with a valid/ack handshake; the granted request is retired only when ack is seen.
- Sits between interrupt/event sources and a single-consumer service unit.

---
 rtl/priority_encoder_pending.sv | 115 +++++++++++
 1 files changed

// File: rtl/priority_encoder_pending.sv
// Sticky pending-request register with a registered highest-index grant.
// A grant is retired only when the consumer acks it.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      request lines; a 1 sets the matching pending bit
//   ack      consumer accepts the current grant; ignored while valid=0
//   mask     (PRIORITY_ENCODER_MASK_EN only) bits excluded from selection
//   valid    idx holds a live grant
//   idx      index of the granted request (MSB = highest priority)
//   pending  sticky request vector, including the granted bit
//   dup      one-cycle pulse when a req hits an already-pending bit
//
// Optional feature macro: PRIORITY_ENCODER_MASK_EN.
// When it is defined, a mask port is added and masked bits still
// accumulate in pending but are never selected.
module priority_encoder_pending #(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             ack,
`ifdef PRIORITY_ENCODER_MASK_EN
    input  logic [N-1:0]     mask,
`endif
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     pending,
    output logic             dup
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     pend_q, pend_d;
    logic             dup_q, dup_d;

    logic [N-1:0]     clr;
    logic [N-1:0]     p_eff;
    logic [N-1:0]     sel;

    // Highest set bit; always < N, so unused codes never appear.
    function automatic logic [IDX_W-1:0] top_bit(input logic [N-1:0] v);
        top_bit = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                top_bit = IDX_W'(i);
            end
        end
    endfunction

    always_comb begin
        clr    = (state_q == GRANT && ack) ? (N'(1) << idx_q) : '0;
        p_eff  = pend_q & ~clr;
        pend_d = p_eff | req;
        // A bit cleared this cycle and re-requested is not a duplicate.
        dup_d  = |(req & p_eff);
`ifdef PRIORITY_ENCODER_MASK_EN
        sel    = pend_d & ~mask;
`else
        sel    = pend_d;
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (|sel) begin
                    state_d = GRANT;
                    idx_d   = top_bit(sel);
                end
            end
            GRANT: begin
                // No preemption: the grant only moves on ack.
                if (ack) begin
                    if (|sel) begin
                        idx_d = top_bit(sel);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            dup_q   <= dup_d;
        end
    end

    assign valid   = (state_q == GRANT);
    assign idx     = idx_q;
    assign pending = pend_q;
    assign dup     = dup_q;

endmodule
